// File: rtl/binary_morph_3x3_if.sv
// -----------------------------------------------------------------------------
// binary_morph_3x3_if
// Pixel stream bundle for the 3x3 binary morphology engine.
//   mode     : operation select, sampled with an accepted din_sof
//   din      : input pixel, din_vld valid, din_sof first pixel of frame
//   din_rdy  : engine can accept a pixel (low while flushing)
//   dout     : output pixel (all-ones or all-zeros), dout_vld valid,
//              dout_sof first output pixel of frame
// master drives the input side (upstream / bench), slave is the engine.
// -----------------------------------------------------------------------------
interface binary_morph_3x3_if #(
  parameter int DATA_W = 24
) ();
  logic [1:0]        mode;
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic              din_sof;
  logic              din_rdy;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              dout_sof;

  modport master (
    output mode, din, din_vld, din_sof,
    input  din_rdy, dout, dout_vld, dout_sof
  );

  modport slave (
    input  mode, din, din_vld, din_sof,
    output din_rdy, dout, dout_vld, dout_sof
  );
endinterface

// File: rtl/binary_morph_3x3.sv
// -----------------------------------------------------------------------------
// binary_morph_3x3
// 3x3 binary dilation / erosion / bypass on a raster pixel stream. Each pixel
// is binarised on its MSB, two 1-bit line buffers plus a 3-column window
// hold the neighbourhood, and the result is emitted as a full-width
// black/white pixel one clock after the accept that completes its window.
// At end of frame the last row+1 pixels are flushed with virtual inputs
// while din_rdy is held low.
// Ports:
//   clk     : pixel clock
//   rst_n   : asynchronous active-low reset
//   bus_if  : slave side of binary_morph_3x3_if (mode, din*, dout*)
// -----------------------------------------------------------------------------
module binary_morph_3x3 #(
  parameter int DATA_W = 24,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  binary_morph_3x3_if.slave    bus_if
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1) + 1;

  localparam logic [CW-1:0] COL_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] COL_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ZERO   = {RW{1'b0}};
  localparam logic [RW-1:0] ROW_ONE    = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] FLUSH_ONE  = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

  localparam logic [1:0] MODE_BYP = 2'b00;
  localparam logic [1:0] MODE_DIL = 2'b01;
  localparam logic [1:0] MODE_ERO = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  // Window bit order: index = row*3 + col, row 0 = top, col 0 = left.
  // Out-of-image neighbours are replaced by the neutral pad value of the
  // operation (0 for OR, 1 for AND) so borders neither grow nor erode.
  function automatic logic morph_op(input logic [1:0] op,
                                    input logic [8:0] win,
                                    input logic [8:0] ok);
    logic       pad;
    logic [8:0] eff;
    logic       res;
    case (op)
      MODE_DIL: pad = 1'b0;
      MODE_ERO: pad = 1'b1;
      default:  pad = 1'b0;
    endcase
    eff = (win & ok) | ({9{pad}} & ~ok);
    case (op)
      MODE_DIL: res = |eff;
      MODE_ERO: res = &eff;
      default:  res = win[4];
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CW-1:0]     in_col_q, in_col_d;
  logic [RW-1:0]     in_row_q, in_row_d;
  logic [CW-1:0]     out_col_q, out_col_d;
  logic [RW-1:0]     out_row_q, out_row_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              din_rdy_q, din_rdy_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              dout_sof_q, dout_sof_d;

  logic [IMG_W-1:0]  lb_top_q;   // row two above the incoming pixel
  logic [IMG_W-1:0]  lb_mid_q;   // row directly above the incoming pixel
  logic [2:0]        col_l_q;    // older window column (left of centre)
  logic [2:0]        col_c_q;    // newer window column (centre)

  logic              acc_s;
  logic              sof_acc_s;
  logic              shift_s;
  logic              restart_s;
  logic              emit_s;
  logic              bit_in_s;
  logic [CW-1:0]     col_idx_s;
  logic [RW-1:0]     row_cur_s;
  logic [2:0]        new_col_s;
  logic [8:0]        win_s;
  logic [8:0]        ok_s;
  logic [2:0]        row_ok_s;
  logic [2:0]        col_ok_s;
  logic              result_s;

  assign acc_s     = bus_if.din_vld & din_rdy_q;
  assign sof_acc_s = acc_s & bus_if.din_sof;

  // A restarting pixel is always pixel (0,0) of the new frame.
  assign col_idx_s = restart_s ? COL_ZERO : in_col_q;
  assign row_cur_s = restart_s ? ROW_ZERO : in_row_q;
  assign new_col_s = {bit_in_s, lb_mid_q[col_idx_s], lb_top_q[col_idx_s]};

  assign win_s = {new_col_s[2], col_c_q[2], col_l_q[2],
                  new_col_s[1], col_c_q[1], col_l_q[1],
                  new_col_s[0], col_c_q[0], col_l_q[0]};

  assign row_ok_s = {out_row_q != ROW_LAST, 1'b1, out_row_q != ROW_ZERO};
  assign col_ok_s = {out_col_q != COL_LAST, 1'b1, out_col_q != COL_ZERO};

  // Expand row/column in-image flags into a per-neighbour mask.
  always_comb begin
    ok_s = 9'b0_0000_0000;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        ok_s[r*3+c] = row_ok_s[r] & col_ok_s[c];
      end
    end
  end

  assign result_s = morph_op(mode_q, win_s, ok_s);

  // FSM next state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    flush_d   = flush_q;
    din_rdy_d = 1'b1;
    shift_s   = 1'b0;
    restart_s = 1'b0;
    emit_s    = 1'b0;
    bit_in_s  = bus_if.din[DATA_W-1];
    case (state_q)
      S_IDLE: begin
        if (sof_acc_s) begin
          restart_s = 1'b1;
          shift_s   = 1'b1;
          mode_d    = bus_if.mode;
          state_d   = S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (sof_acc_s) begin
          restart_s = 1'b1;
          shift_s   = 1'b1;
          mode_d    = bus_if.mode;
          state_d   = S_FILL;
        end else if (acc_s) begin
          shift_s = 1'b1;
          // Pixel (1,1) completes the window around (0,0).
          if (in_row_q == ROW_ONE && in_col_q == COL_ONE) begin
            emit_s  = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_RUN: begin
        if (sof_acc_s) begin
          restart_s = 1'b1;
          shift_s   = 1'b1;
          mode_d    = bus_if.mode;
          state_d   = S_FILL;
        end else if (acc_s) begin
          shift_s = 1'b1;
          emit_s  = 1'b1;
          if (in_row_q == ROW_LAST && in_col_q == COL_LAST) begin
            state_d   = S_FLUSH;
            flush_d   = FLUSH_ZERO;
            din_rdy_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        // Virtual input; its value is always masked by bottom-row padding.
        shift_s  = 1'b1;
        emit_s   = 1'b1;
        bit_in_s = 1'b0;
        if (flush_q == FLUSH_LAST) begin
          state_d = S_IDLE;
        end else begin
          flush_d   = flush_q + FLUSH_ONE;
          din_rdy_d = 1'b0;
          state_d   = S_FLUSH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Geometry counters and output register next values.
  always_comb begin
    in_col_d   = in_col_q;
    in_row_d   = in_row_q;
    out_col_d  = out_col_q;
    out_row_d  = out_row_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    dout_sof_d = 1'b0;
    if (shift_s) begin
      if (col_idx_s == COL_LAST) begin
        in_col_d = COL_ZERO;
        in_row_d = (row_cur_s == ROW_LAST) ? ROW_ZERO : row_cur_s + ROW_ONE;
      end else begin
        in_col_d = col_idx_s + COL_ONE;
        in_row_d = row_cur_s;
      end
    end else begin
      in_col_d = in_col_q;
      in_row_d = in_row_q;
    end
    if (restart_s) begin
      out_col_d = COL_ZERO;
      out_row_d = ROW_ZERO;
    end else if (emit_s) begin
      if (out_col_q == COL_LAST) begin
        out_col_d = COL_ZERO;
        out_row_d = (out_row_q == ROW_LAST) ? ROW_ZERO : out_row_q + ROW_ONE;
      end else begin
        out_col_d = out_col_q + COL_ONE;
        out_row_d = out_row_q;
      end
    end else begin
      out_col_d = out_col_q;
      out_row_d = out_row_q;
    end
    if (emit_s) begin
      dout_d     = {DATA_W{result_s}};
      dout_vld_d = 1'b1;
      dout_sof_d = (out_col_q == COL_ZERO) && (out_row_q == ROW_ZERO);
    end else begin
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
      dout_sof_d = 1'b0;
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_BYP;
      in_col_q   <= COL_ZERO;
      in_row_q   <= ROW_ZERO;
      out_col_q  <= COL_ZERO;
      out_row_q  <= ROW_ZERO;
      flush_q    <= FLUSH_ZERO;
      din_rdy_q  <= 1'b1;
      dout_q     <= {DATA_W{1'b0}};
      dout_vld_q <= 1'b0;
      dout_sof_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      in_col_q   <= in_col_d;
      in_row_q   <= in_row_d;
      out_col_q  <= out_col_d;
      out_row_q  <= out_row_d;
      flush_q    <= flush_d;
      din_rdy_q  <= din_rdy_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_sof_q <= dout_sof_d;
    end
  end

  // Line buffers and window columns; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (shift_s) begin
      lb_top_q[col_idx_s] <= lb_mid_q[col_idx_s];
      lb_mid_q[col_idx_s] <= bit_in_s;
      col_l_q             <= col_c_q;
      col_c_q             <= new_col_s;
    end
  end

  assign bus_if.din_rdy  = din_rdy_q;
  assign bus_if.dout     = dout_q;
  assign bus_if.dout_vld = dout_vld_q;
  assign bus_if.dout_sof = dout_sof_q;

endmodule
